pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program counter with a hardware return-address stack, the next-generation PC for the CPU fetch path. It drives the instruction-memory address from a single registered PC. It supports absolute load, sign-extended relative branch, increment, and call/return with a LIFO of return addresses. Overflow and underflow are flagged, and the PC is held on both.

## Interface
- ADDR_W, 5: PC / address width in bits (≥2).
- STACK_DEPTH, 4: return-stack entries (≥1).
- RESET_VEC, 0: PC value loaded on reset (ADDR_W bits).
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; low = freeze all state.
- load_pc  input  1  absolute jump to pc_addin.
- inc_pc  input  1  PC + 1.
- branch_rel  input  1  PC + sign-extended rel_off.
- call  input  1  push PC+1, jump to pc_addin.
- ret  input  1  pop return address into PC.
- clr_err  input  1  clear sticky err.
- pc_addin  input  ADDR_W  absolute target.
- rel_off  input  ADDR_W  signed two's-complement offset.
- pc_addout  output  ADDR_W  current PC (direct register output).
- stack_full  output  1  depth == STACK_DEPTH.
- stack_empty  output  1  depth == 0.
- stack_depth  output  $clog2(STACK_DEPTH+1)  current entry count.
- err  output  1  sticky overflow/underflow flag.

## Operation
- One PC register. pc_addout is that register, with no extra pipeline stage.
- Command priority when en=1, highest first: ret > call > load_pc > branch_rel > inc_pc > hold. Only the winning command takes effect. Lower commands asserted in the same cycle are ignored.
- ret, stack non-empty:
  - PC ← top entry.
  - depth −1.
- ret, stack empty:
  - PC holds, depth stays 0.
  - err ← 1.
- call, stack not full:
  - Push (PC+1) mod 2^ADDR_W.
  - PC ← pc_addin.
  - depth +1.
- call, stack full:
  - No push, PC holds, depth unchanged.
  - err ← 1.
- load_pc: PC ← pc_addin.
- branch_rel: PC ← (PC + sext(rel_off)) mod 2^ADDR_W.
- inc_pc: PC ← (PC + 1) mod 2^ADDR_W.
- All arithmetic wraps modulo 2^ADDR_W. No carry or overflow indication for PC arithmetic.
- Stack is LIFO. Entries above depth are don't-care and are never read.
- err is sticky:
  - Set on overflow or underflow.
  - Cleared by clr_err.
  - If set and clear occur in the same cycle, set wins.
  - clr_err is honoured regardless of en.
- en=0:
  - PC, stack and depth hold.
  - No err set from commands.
  - Command inputs are ignored.

## Timing
- Reset (rst=0, async, immediate):
  - pc_addout=RESET_VEC.
  - stack_depth=0, stack_empty=1, stack_full=0.
  - err=0.
  - Stack contents are not cleared.
- Reset asserted mid-operation, including during a call/ret cycle, aborts the update. State after release equals the reset values.
- Commands are sampled at a rising edge. The result is visible on pc_addout immediately after that edge, giving 1-cycle latency.
- stack_full, stack_empty and stack_depth are registered. They reflect the post-edge depth in the same cycle as pc_addout.
- Back-to-back call/ret on consecutive cycles are supported at full rate. A ret immediately after a call returns the just-pushed PC+1.
- Call when PC = 2^ADDR_W−1 pushes 0.

## Test plan
- Reset then inc: hold rst=0, check pc_addout=RESET_VEC (0). Release, inc_pc=1 for 33 cycles with ADDR_W=5 → PC reaches 31 then wraps to 0, ending at 1.
- Priority: PC=3, assert load_pc=1 (addin=10), inc_pc=1 and branch_rel=1 together → PC=10. Then inc_pc=1 with en=0 for 3 cycles → PC stays 10.
- Relative branch: PC=20, rel_off=5'b11101 (−3) → 17. PC=30, rel_off=4 → 2 (wrap).
- Call/return nesting: PC=2. call addin=8, call addin=16, ret, ret → PC sequence 8, 16, 9, 3, with depth 1, 2, 1, 0 and err=0.
- Overflow/underflow:
  - Fill 4 calls (stack_full=1). A 5th call keeps PC and depth=4 and sets err=1.
  - clr_err → err=0.
  - Pop 4 times. A 5th ret keeps PC and sets err=1.
- Async reset mid-call: assert rst=0 between edges while depth=2 and call is pending → pc_addout=RESET_VEC and stack_depth=0 immediately. The pending call has no effect after release.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Command/status bundle between fetch control and the PC sequencer.
// Latency: none (wires only).
// Backpressure: none; commands are sampled by the sequencer every enabled cycle.
//   master: drives en, commands, clr_err, pc_addin, rel_off; observes PC and stack status
//   slave : the sequencer side of the same signals
interface pc_sequencer_if #(
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic              en;
  logic              load_pc;
  logic              inc_pc;
  logic              branch_rel;
  logic              call;
  logic              ret;
  logic              clr_err;
  logic [ADDR_W-1:0] pc_addin;
  logic [ADDR_W-1:0] rel_off;
  logic [ADDR_W-1:0] pc_addout;
  logic              stack_full;
  logic              stack_empty;
  logic [DW-1:0]     stack_depth;
  logic              err;

  modport master (
    output en, load_pc, inc_pc, branch_rel, call, ret, clr_err, pc_addin, rel_off,
    input  pc_addout, stack_full, stack_empty, stack_depth, err
  );

  modport slave (
    input  en, load_pc, inc_pc, branch_rel, call, ret, clr_err, pc_addin, rel_off,
    output pc_addout, stack_full, stack_empty, stack_depth, err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with return-address stack; priority ret > call > load > branch > inc.
// Latency: 1 cycle, command at a rising edge is visible on pc_addout right after it.
// Backpressure: none; en=0 freezes PC/stack/depth, overflow/underflow hold PC and set err.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (PC=RESET_VEC, depth=0, err=0; stack RAM untouched)
//   bus : pc_sequencer_if.slave (commands in, PC and stack status out)
module pc_sequencer #(
  parameter int                ADDR_W      = 5,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              push;
  logic              err_set;
  logic [ADDR_W-1:0] pc_inc;
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     push_idx;

  // PC+1 serves both increment and the call return address; wraps naturally.
  assign pc_inc   = pc_q + ADDR_W'(1);
  // Index math only matters when the stack is non-empty (read) or not full (write).
  assign top_idx  = IW'(depth_q - DW'(1));
  assign push_idx = IW'(depth_q);

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    err_set = 1'b0;
    push    = 1'b0;
    if (bus.en) begin
      if (bus.ret) begin
        if (depth_q != '0) begin
          pc_d    = stack_q[top_idx];
          depth_d = depth_q - DW'(1);
        end else begin
          err_set = 1'b1;
        end
      end else if (bus.call) begin
        if (depth_q != DEPTH_MAX) begin
          push    = 1'b1;
          pc_d    = bus.pc_addin;
          depth_d = depth_q + DW'(1);
        end else begin
          err_set = 1'b1;
        end
      end else if (bus.load_pc) begin
        pc_d = bus.pc_addin;
      end else if (bus.branch_rel) begin
        // Same-width add is exactly PC + sext(rel_off) modulo 2^ADDR_W.
        pc_d = pc_q + bus.rel_off;
      end else if (bus.inc_pc) begin
        pc_d = pc_inc;
      end
    end
    // Set beats clear; clear works even with en low.
    err_d   = err_set | (err_q & ~bus.clr_err);
    full_d  = (depth_d == DEPTH_MAX);
    empty_d = (depth_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Stack storage is not reset; a write during reset is suppressed so a
  // pending call cannot leave a trace.
  always_ff @(posedge clk) begin
    if (push && rst) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign bus.pc_addout   = pc_q;
  assign bus.stack_depth = depth_q;
  assign bus.stack_full  = full_q;
  assign bus.stack_empty = empty_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam int AW = 5;
  localparam int SD = 4;
  localparam logic [AW-1:0] RV = '0;
  localparam int MODV = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks   = 0;
  int failures = 0;

  pc_sequencer_if #(.ADDR_W(AW), .STACK_DEPTH(SD)) bus();

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_VEC(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: PC as an integer, return stack as a queue.
  int mpc = int'(RV);
  int stk[$];
  bit merr = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mpc  = int'(RV);
      stk.delete();
      merr = 1'b0;
    end else begin
      bit set_e;
      int off;
      set_e = 1'b0;
      if (bus.en) begin
        if (bus.ret) begin
          if (stk.size() > 0) mpc = stk.pop_back();
          else set_e = 1'b1;
        end else if (bus.call) begin
          if (stk.size() < SD) begin
            stk.push_back((mpc + 1) % MODV);
            mpc = int'(bus.pc_addin);
          end else set_e = 1'b1;
        end else if (bus.load_pc) begin
          mpc = int'(bus.pc_addin);
        end else if (bus.branch_rel) begin
          off = int'(bus.rel_off);
          if (off >= MODV / 2) off = off - MODV;
          mpc = ((mpc + off) % MODV + MODV) % MODV;
        end else if (bus.inc_pc) begin
          mpc = (mpc + 1) % MODV;
        end
      end
      merr = set_e || (merr && !bus.clr_err);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, the outputs must match the model.
  always @(negedge clk) begin
    chk("cyc_pc",    int'(bus.pc_addout),   mpc);
    chk("cyc_depth", int'(bus.stack_depth), stk.size());
    chk("cyc_full",  int'(bus.stack_full),  (stk.size() == SD) ? 1 : 0);
    chk("cyc_empty", int'(bus.stack_empty), (stk.size() == 0) ? 1 : 0);
    chk("cyc_err",   int'(bus.err),         merr ? 1 : 0);
  end

  task automatic idle();
    bus.en = 1'b1; bus.load_pc = 1'b0; bus.inc_pc = 1'b0; bus.branch_rel = 1'b0;
    bus.call = 1'b0; bus.ret = 1'b0; bus.clr_err = 1'b0;
    bus.pc_addin = '0; bus.rel_off = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int a);
    idle(); bus.load_pc = 1'b1; bus.pc_addin = AW'(a); tick(); idle();
  endtask

  task automatic do_call(input int a);
    idle(); bus.call = 1'b1; bus.pc_addin = AW'(a); tick(); idle();
  endtask

  task automatic do_ret();
    idle(); bus.ret = 1'b1; tick(); idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    tick(); tick();
    chk("rst_pc",    int'(bus.pc_addout), 0);
    chk("rst_depth", int'(bus.stack_depth), 0);
    chk("rst_empty", int'(bus.stack_empty), 1);
    chk("rst_full",  int'(bus.stack_full), 0);
    chk("rst_err",   int'(bus.err), 0);
    rst = 1'b1;

    // Increment through the wrap.
    bus.inc_pc = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick();
      if (i == 31) chk("inc_31", int'(bus.pc_addout), 31);
      if (i == 32) chk("inc_wrap", int'(bus.pc_addout), 0);
      if (i == 33) chk("inc_end", int'(bus.pc_addout), 1);
    end
    idle();

    // Priority: load beats branch and inc; en=0 freezes.
    do_load(3);
    chk("load3", int'(bus.pc_addout), 3);
    bus.load_pc = 1'b1; bus.pc_addin = 5'd10; bus.inc_pc = 1'b1;
    bus.branch_rel = 1'b1; bus.rel_off = 5'd5;
    tick(); idle();
    chk("prio_load", int'(bus.pc_addout), 10);
    bus.en = 1'b0; bus.inc_pc = 1'b1;
    repeat (3) tick();
    idle();
    chk("en_hold", int'(bus.pc_addout), 10);

    // Relative branches.
    do_load(20);
    bus.branch_rel = 1'b1; bus.rel_off = 5'b11101; tick(); idle();
    chk("br_neg", int'(bus.pc_addout), 17);
    do_load(30);
    bus.branch_rel = 1'b1; bus.rel_off = 5'd4; tick(); idle();
    chk("br_wrap", int'(bus.pc_addout), 2);
    // Branch beats inc.
    bus.branch_rel = 1'b1; bus.inc_pc = 1'b1; bus.rel_off = 5'd3; tick(); idle();
    chk("prio_br", int'(bus.pc_addout), 5);

    // Call/return nesting.
    do_load(2);
    do_call(8);
    chk("nest_pc1", int'(bus.pc_addout), 8);
    chk("nest_d1",  int'(bus.stack_depth), 1);
    do_call(16);
    chk("nest_pc2", int'(bus.pc_addout), 16);
    chk("nest_d2",  int'(bus.stack_depth), 2);
    do_ret();
    chk("nest_pc3", int'(bus.pc_addout), 9);
    chk("nest_d3",  int'(bus.stack_depth), 1);
    do_ret();
    chk("nest_pc4", int'(bus.pc_addout), 3);
    chk("nest_d4",  int'(bus.stack_depth), 0);
    chk("nest_err", int'(bus.err), 0);

    // Overflow.
    do_call(10); do_call(11); do_call(12); do_call(13);
    chk("ovf_full", int'(bus.stack_full), 1);
    do_call(20);
    chk("ovf_pc",    int'(bus.pc_addout), 13);
    chk("ovf_depth", int'(bus.stack_depth), 4);
    chk("ovf_err",   int'(bus.err), 1);
    // Clear works with en low.
    bus.en = 1'b0; bus.clr_err = 1'b1; tick(); idle();
    chk("clr_err", int'(bus.err), 0);

    // Underflow.
    do_ret(); chk("pop1", int'(bus.pc_addout), 13);
    do_ret(); chk("pop2", int'(bus.pc_addout), 12);
    do_ret(); chk("pop3", int'(bus.pc_addout), 11);
    do_ret(); chk("pop4", int'(bus.pc_addout), 4);
    chk("pop_empty", int'(bus.stack_empty), 1);
    // Underflow with clr_err in the same cycle: set wins.
    bus.ret = 1'b1; bus.clr_err = 1'b1; tick(); idle();
    chk("udf_pc",  int'(bus.pc_addout), 4);
    chk("udf_err", int'(bus.err), 1);
    bus.clr_err = 1'b1; tick(); idle();

    // ret beats call; call at all-ones pushes 0.
    do_load(31);
    do_call(5);
    chk("call_top", int'(bus.pc_addout), 5);
    bus.call = 1'b1; bus.ret = 1'b1; bus.pc_addin = 5'd7; tick(); idle();
    chk("ret_wrap", int'(bus.pc_addout), 0);
    chk("ret_prio_depth", int'(bus.stack_depth), 0);

    // Async reset with a call pending.
    do_load(1);
    do_call(5);
    do_call(6);
    chk("pre_rst_depth", int'(bus.stack_depth), 2);
    bus.call = 1'b1; bus.pc_addin = 5'd9;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pc",    int'(bus.pc_addout), 0);
    chk("arst_depth", int'(bus.stack_depth), 0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    chk("post_rst_pc",    int'(bus.pc_addout), 0);
    chk("post_rst_depth", int'(bus.stack_depth), 0);
    chk("post_rst_err",   int'(bus.err), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
